axi_ar_beat_gen: RTL
====================

# axi_ar_beat_gen

Read-address beat generator that sits directly downstream of the AR-channel buffer. It accepts one AXI4 AR request at a time and expands it into one address per beat on a valid/ready beat channel. Each beat carries the request's ID and user fields and a last flag. The beat channel feeds the memory-side read port of an AXI slave adapter.

## Interface
- ID_WIDTH, 4, AR ID width
- ADDR_WIDTH, 32, address width
- USER_WIDTH, 6, AR user width
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, synchronous and active-high
- ar_valid_i  in  1  AR request valid
- ar_addr_i  in  ADDR_WIDTH  start address
- ar_len_i  in  8  beats minus one
- ar_size_i  in  3  bytes per beat = 2^size
- ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- ar_id_i  in  ID_WIDTH  transaction ID
- ar_user_i  in  USER_WIDTH  user sideband
- ar_ready_o  out  1  request accepted when high with ar_valid_i
- beat_valid_o  out  1  beat address valid
- beat_addr_o  out  ADDR_WIDTH  address of current beat
- beat_id_o  out  ID_WIDTH  latched ar_id_i
- beat_user_o  out  USER_WIDTH  latched ar_user_i
- beat_last_o  out  1  current beat is final beat of burst
- beat_ready_i  in  1  consumer takes beat

## Operation
- FSM states are IDLE and BURST.
- IDLE: ar_ready_o=1, beat_valid_o=0.
- On ar_valid_i&ar_ready_o:
  - latch addr, len, size, burst, id and user;
  - clear beat counter cnt (8 bit);
  - go to BURST.
- BURST: ar_ready_o=0, beat_valid_o=1, beat_last_o=(cnt==len).
- On beat_valid_o&beat_ready_i:
  - if last, go to IDLE;
  - otherwise cnt+=1 and addr=next_addr.
- next_addr, with B=2^size:
  - FIXED: addr unchanged.
  - INCR: (addr & ~(B-1)) + B. The sum truncates modulo 2^ADDR_WIDTH. No 4 KB boundary check.
  - WRAP: W = (len+1)*B and base = addr & ~(W-1). Result is base | (((addr & ~(B-1)) + B) & (W-1)).
  - WRAP with len not in {1,3,7,15} is treated as INCR.
  - Reserved burst 11 is treated as INCR.
- The first beat address is ar_addr_i unmodified, including unaligned bits.
- beat_addr_o, beat_id_o and beat_user_o hold stable while beat_valid_o=1 and beat_ready_i=0.
- beat_valid_o never drops without a handshake.
- ar_prot, region, lock, cache and qos are not inputs. The upstream stage drops them.

## Timing
- Reset (rst_i high at a clock edge) forces IDLE and clears all registers.
- While rst_i is sampled high, ar_ready_o=0 and beat_valid_o=0. ar_ready_o is gated by a registered reset flag.
- Outputs during reset: beat_addr_o=0, beat_id_o=0, beat_user_o=0, beat_last_o=0.
- Reset asserted mid-burst aborts the burst; remaining beats are never issued.
- AR handshake in cycle N gives the first beat_valid_o in cycle N+1.
- Beat throughput is 1 beat/cycle while beat_ready_i=1.
- A burst of len L occupies L+1 BURST cycles minimum.
- Back-to-back bursts have one IDLE cycle between them. ar_ready_o is purely state-decoded and has no combinational path from beat_ready_i.
- len=0 gives a single beat with beat_last_o=1 in the first BURST cycle.
- len=255 runs cnt up to 255 with no wrap. The burst ends on that beat.
- beat_ready_i held high in IDLE has no effect.

## Structure
- Shared package axi_beat_pkg holds:
  - burst encoding constants BURST_FIXED, BURST_INCR, BURST_WRAP;
  - state enum type;
  - a pure function for next-address computation, parameterised by ADDR_WIDTH.
- One combinational sub-module, axi_beat_addr_calc:
  - inputs addr, len, size, burst; output next_addr;
  - reusable by the AW-side write beat generator.
- FSM, counter and sideband registers live in the top module.

## Test plan
- INCR, addr 0x1000, len 3, size 2, beat_ready_i=1 -> beats 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles. Last beat flagged only on 0x100C. ar_ready_o returns 1 the next cycle.
- WRAP, addr 0x1038, len 3, size 3 -> beats 0x1038, 0x1020, 0x1028, 0x1030, last on 0x1030.
- FIXED, addr 0x2002, len 2, size 0, beat_ready_i toggling 1/0 -> three beats, all 0x2002. Outputs held stable through stall cycles. id/user unchanged.
- INCR, unaligned addr 0x0003, len 1, size 2 -> beats 0x0003 then 0x0004.
- INCR wrap-around, ADDR_WIDTH=32, addr 0xFFFFFFFC, len 1, size 2 -> beats 0xFFFFFFFC then 0x00000000.
- rst_i asserted on the 2nd beat of a len-7 burst -> beat_valid_o=0 and ar_ready_o=0 while reset is sampled high. ar_ready_o=1 on the cycle after rst_i is sampled low. No further beats.

Source files
------------

// File: rtl/axi_beat_pkg.sv
// rtl/axi_beat_pkg.sv - burst encodings, FSM state type and next-beat address function
package axi_beat_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Works on a 64-bit container; addr_width masks the result so INCR rolls over modulo 2^addr_width.
  function automatic logic [63:0] next_beat_addr(
    input logic [63:0]  addr,
    input logic [7:0]   len,
    input logic [2:0]   size,
    input logic [1:0]   burst,
    input int unsigned  addr_width
  );
    logic [63:0] bytes;
    logic [63:0] aligned;
    logic [63:0] incr;
    logic [63:0] wrap_bytes;
    logic [63:0] wrap_base;
    logic [63:0] amask;
    logic [63:0] res;
    logic        wrap_ok;
    bytes      = 64'd1 << size;
    aligned    = addr & ~(bytes - 64'd1);
    incr       = aligned + bytes;
    wrap_bytes = ({56'd0, len} + 64'd1) << size;
    wrap_base  = addr & ~(wrap_bytes - 64'd1);
    wrap_ok    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    amask      = (addr_width >= 32'd64) ? '1 : ((64'd1 << addr_width) - 64'd1);
    case (burst)
      BURST_FIXED: res = addr;
      BURST_WRAP:  res = wrap_ok ? (wrap_base | (incr & (wrap_bytes - 64'd1))) : incr;
      default:     res = incr;
    endcase
    return res & amask;
  endfunction

endpackage

// File: rtl/axi_beat_addr_calc.sv
// rtl/axi_beat_addr_calc.sv - combinational next-beat address for AR/AW beat generators
module axi_beat_addr_calc
  import axi_beat_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  assign next_addr = ADDR_WIDTH'(next_beat_addr(64'(addr), len, size, burst, ADDR_WIDTH));

endmodule

// File: rtl/axi_ar_beat_gen.sv
// rtl/axi_ar_beat_gen.sv - expands one AR request at a time into per-beat addresses
module axi_ar_beat_gen
  import axi_beat_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ar_valid_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [USER_WIDTH-1:0] ar_user_i,
  output logic                  ar_ready_o,
  output logic                  beat_valid_o,
  output logic [ADDR_WIDTH-1:0] beat_addr_o,
  output logic [ID_WIDTH-1:0]   beat_id_o,
  output logic [USER_WIDTH-1:0] beat_user_o,
  output logic                  beat_last_o,
  input  logic                  beat_ready_i
);

  state_t                state_q;
  state_t                state_d;
  logic                  rst_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [7:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  ar_fire;
  logic                  beat_fire;

  axi_beat_addr_calc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_calc (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // ar_ready_o decodes only state and the registered reset flag, never beat_ready_i.
  always_comb begin
    state_d      = state_q;
    ar_ready_o   = 1'b0;
    beat_valid_o = 1'b0;
    beat_last_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ar_ready_o = ~rst_q;
        if (ar_valid_i && !rst_q) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        beat_valid_o = 1'b1;
        beat_last_o  = (cnt_q == len_q);
        if (beat_ready_i && (cnt_q == len_q)) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign ar_fire   = ar_valid_i & ar_ready_o;
  assign beat_fire = beat_valid_o & beat_ready_i;

  always_ff @(posedge clk_i) begin
    rst_q <= rst_i;
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      user_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ar_fire) begin
        addr_q  <= ar_addr_i;
        len_q   <= ar_len_i;
        size_q  <= ar_size_i;
        burst_q <= ar_burst_i;
        id_q    <= ar_id_i;
        user_q  <= ar_user_i;
        cnt_q   <= '0;
      end else if (beat_fire && !beat_last_o) begin
        cnt_q  <= cnt_q + 8'd1;
        addr_q <= next_addr;
      end
    end
  end

  assign beat_addr_o = addr_q;
  assign beat_id_o   = id_q;
  assign beat_user_o = user_q;

endmodule
